main_memory_interface: RTL and testbench

- Bridges the last-level cache, which moves whole lines, and main memory, which moves single words.
- A line read, write-back or flush from the cache becomes WORDS_PER_LINE sequential single-word memory transactions.
- Once all words are done, the block returns one line-wide response to the cache.
- It sits between the LLC miss/write-back port and the main-memory port.

---
 rtl/main_memory_interface.sv | 176 +++++++++++++++++
 tb/tb_main_memory_interface.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | main_memory_interface                                                    |
// |                                                                          |
// | Bridges a line-oriented last-level cache and a word-oriented main        |
// | memory. A cache read (R_REQ), write-back (WB_REQ) or flush (FLUSH) is    |
// | split into WORDS_PER_LINE sequential single-word memory transactions,    |
// | starting at the line base (request address with the offset cleared).     |
// | When every word has been acknowledged, one line-wide MEM_RESP goes back  |
// | to the cache and is held until the cache returns to NO_REQ.              |
// |                                                                          |
// | Ports:                                                                   |
// |   clock, reset                 clock and async active-high reset         |
// |   cache2interface_msg/address/data   line request from the cache        |
// |   interface2cache_msg/address/data   line response to the cache         |
// |   mem2interface_msg/address/data     per-word acknowledge from memory   |
// |   interface2mem_msg/address/data     per-word request to memory         |
// |                                                                          |
// | Build option: MAIN_MEM_IF_ADDR_CHECK_EN                                  |
// |   defined   - MEM_RESP accepted only if its address matches the current  |
// |               word address (stale acknowledges are ignored)              |
// |   undefined - any MEM_RESP is accepted; memory must pulse MEM_RESP for   |
// |               exactly one cycle per word                                 |
// |                                                                          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module main_memory_interface #(
  parameter int OFFSET_BITS      = 2,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDRESS_WIDTH    = 12,
  parameter int MSG_BITS         = 4,
  localparam int WORDS_PER_LINE  = 1 << OFFSET_BITS,
  localparam int BUS_WIDTH       = DATA_WIDTH * WORDS_PER_LINE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MSG_BITS-1:0]      cache2interface_msg,
  input  logic [ADDRESS_WIDTH-1:0] cache2interface_address,
  input  logic [BUS_WIDTH-1:0]     cache2interface_data,
  output logic [MSG_BITS-1:0]      interface2cache_msg,
  output logic [ADDRESS_WIDTH-1:0] interface2cache_address,
  output logic [BUS_WIDTH-1:0]     interface2cache_data,
  input  logic [MSG_BITS-1:0]      mem2interface_msg,
  input  logic [ADDRESS_WIDTH-1:0] mem2interface_address,
  input  logic [DATA_WIDTH-1:0]    mem2interface_data,
  output logic [MSG_BITS-1:0]      interface2mem_msg,
  output logic [ADDRESS_WIDTH-1:0] interface2mem_address,
  output logic [DATA_WIDTH-1:0]    interface2mem_data
);

  localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] FLUSH    = MSG_BITS'(3);
  localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(4);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_MEMORY  = 2'd1,
    WRITE_MEMORY = 2'd2,
    RESPOND      = 2'd3
  } state_t;

  state_t                   state;
  logic [OFFSET_BITS-1:0]   counter;
  logic [OFFSET_BITS-1:0]   next_counter;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [ADDRESS_WIDTH-1:0] line_base;
  logic [BUS_WIDTH-1:0]     line;
  logic [BUS_WIDTH-1:0]     line_with_word;
  logic [DATA_WIDTH-1:0]    next_write_word;
  logic                     last_word;
  logic                     word_ack;

  assign line_base    = {cache2interface_address[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign next_counter = counter + 1'b1;
  assign last_word    = (counter == OFFSET_BITS'(WORDS_PER_LINE - 1));

`ifdef MAIN_MEM_IF_ADDR_CHECK_EN
  // interface2mem_address always holds base+counter, so it is the word being waited on.
  assign word_ack = (mem2interface_msg == MEM_RESP) &&
                    (mem2interface_address == interface2mem_address);
`else
  logic unused_mem_address;
  assign unused_mem_address = ^mem2interface_address;
  assign word_ack = (mem2interface_msg == MEM_RESP);
`endif

  // Line buffer with the incoming read word merged in, so the final word can
  // be forwarded to the cache in the same cycle it is stored.
  always_comb begin
    line_with_word = line;
    line_with_word[counter*DATA_WIDTH +: DATA_WIDTH] = mem2interface_data;
  end

  // Wraps to word 0 after the last word; only used while more words remain.
  assign next_write_word = line[next_counter*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      counter                 <= '0;
      req_address             <= '0;
      line                    <= '0;
      interface2cache_msg     <= NO_REQ;
      interface2cache_address <= '0;
      interface2cache_data    <= '0;
      interface2mem_msg       <= NO_REQ;
      interface2mem_address   <= '0;
      interface2mem_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (cache2interface_msg == R_REQ) begin
            req_address           <= cache2interface_address;
            interface2mem_msg     <= R_REQ;
            interface2mem_address <= line_base;
            state                 <= READ_MEMORY;
          end else if (cache2interface_msg == WB_REQ || cache2interface_msg == FLUSH) begin
            req_address           <= cache2interface_address;
            line                  <= cache2interface_data;
            interface2mem_msg     <= WB_REQ;
            interface2mem_address <= line_base;
            interface2mem_data    <= cache2interface_data[DATA_WIDTH-1:0];
            state                 <= WRITE_MEMORY;
          end
        end

        READ_MEMORY: begin
          if (word_ack) begin
            line    <= line_with_word;
            counter <= next_counter;
            if (last_word) begin
              interface2mem_msg       <= NO_REQ;
              interface2cache_msg     <= MEM_RESP;
              interface2cache_address <= req_address;
              interface2cache_data    <= line_with_word;
              state                   <= RESPOND;
            end else begin
              interface2mem_address <= interface2mem_address + 1'b1;
            end
          end
        end

        WRITE_MEMORY: begin
          if (word_ack) begin
            counter <= next_counter;
            if (last_word) begin
              interface2mem_msg       <= NO_REQ;
              interface2cache_msg     <= MEM_RESP;
              interface2cache_address <= req_address;
              interface2cache_data    <= line;
              state                   <= RESPOND;
            end else begin
              interface2mem_address <= interface2mem_address + 1'b1;
              interface2mem_data    <= next_write_word;
            end
          end
        end

        RESPOND: begin
          if (cache2interface_msg == NO_REQ) begin
            interface2cache_msg <= NO_REQ;
            counter             <= '0;
            state               <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_main_memory_interface                                                 |
// |                                                                          |
// | Directed scoreboard bench. Stimulus pushes the expected per-word memory  |
// | requests and the expected line response; a memory model pops and        |
// | compares each request as it acknowledges it, and a cache-side monitor    |
// | pops and compares each line response when MEM_RESP rises.                |
// |                                                                          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_main_memory_interface;

  localparam logic [3:0] NO_REQ   = 4'd0;
  localparam logic [3:0] R_REQ    = 4'd1;
  localparam logic [3:0] WB_REQ   = 4'd2;
  localparam logic [3:0] FLUSH    = 4'd3;
  localparam logic [3:0] MEM_RESP = 4'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  c_msg;
  logic [11:0] c_addr;
  logic [31:0] c_data;
  logic [3:0]  i2c_msg;
  logic [11:0] i2c_addr;
  logic [31:0] i2c_data;
  logic [3:0]  m_msg;
  logic [11:0] m_addr;
  logic [7:0]  m_data;
  logic [3:0]  i2m_msg;
  logic [11:0] i2m_addr;
  logic [7:0]  i2m_data;

  // Memory side is driven either by the model or manually by the stimulus.
  logic        model_en;
  logic [3:0]  mdl_msg, man_msg;
  logic [11:0] mdl_addr, man_addr;
  logic [7:0]  mdl_data, man_data;
  assign m_msg  = model_en ? mdl_msg  : man_msg;
  assign m_addr = model_en ? mdl_addr : man_addr;
  assign m_data = model_en ? mdl_data : man_data;

  int tests = 0;
  int fails = 0;
  int delay_tbl [4];
  int wait_cnt  = 0;
  int resp_cnt  = 0;
  logic prev_resp = 1'b0;
  logic [7:0] mem_arr [0:4095];

  typedef struct packed {
    logic [3:0]  msg;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        chk_data;
  } mem_exp_t;
  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } cache_exp_t;
  mem_exp_t   mem_q[$];
  cache_exp_t cache_q[$];

  main_memory_interface dut (
    .clock                   (clock),
    .reset                   (reset),
    .cache2interface_msg     (c_msg),
    .cache2interface_address (c_addr),
    .cache2interface_data    (c_data),
    .interface2cache_msg     (i2c_msg),
    .interface2cache_address (i2c_addr),
    .interface2cache_data    (i2c_data),
    .mem2interface_msg       (m_msg),
    .mem2interface_address   (m_addr),
    .mem2interface_data      (m_data),
    .interface2mem_msg       (i2m_msg),
    .interface2mem_address   (i2m_addr),
    .interface2mem_data      (i2m_data)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory model + request monitor: acknowledges a pending request after the
  // per-word-offset delay, comparing it against the scoreboard at that moment.
  always @(negedge clock) begin
    mdl_msg <= NO_REQ;
    if (reset) begin
      wait_cnt <= 0;
    end else if (model_en && i2m_msg != NO_REQ) begin
      if (wait_cnt < delay_tbl[i2m_addr[1:0]]) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected_req", {20'd0, i2m_addr}, 32'hFFFF_FFFF);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_req_msg", {28'd0, i2m_msg}, {28'd0, e.msg});
          check("mem_req_addr", {20'd0, i2m_addr}, {20'd0, e.addr});
          if (e.chk_data) check("mem_req_data", {24'd0, i2m_data}, {24'd0, e.data});
        end
        mdl_msg  <= MEM_RESP;
        mdl_addr <= i2m_addr;
        mdl_data <= mem_arr[i2m_addr];
        wait_cnt <= 0;
        resp_cnt <= resp_cnt + 1;
      end
    end
  end

  // Cache-side monitor: one comparison set per rising MEM_RESP.
  always @(negedge clock) begin
    if (i2c_msg == MEM_RESP && !prev_resp) begin
      if (cache_q.size() == 0) begin
        check("cache_unexpected_resp", {20'd0, i2c_addr}, 32'hFFFF_FFFF);
      end else begin
        cache_exp_t e;
        e = cache_q.pop_front();
        check("cache_resp_addr", {20'd0, i2c_addr}, {20'd0, e.addr});
        check("cache_resp_data", i2c_data, e.data);
      end
    end
    prev_resp <= (i2c_msg == MEM_RESP);
  end

  task automatic exp_mem(input logic [3:0] msg, input logic [11:0] addr, input logic [7:0] data, input logic chk);
    mem_exp_t e;
    e.msg = msg; e.addr = addr; e.data = data; e.chk_data = chk;
    mem_q.push_back(e);
  endtask

  task automatic exp_cache(input logic [11:0] addr, input logic [31:0] data);
    cache_exp_t e;
    e.addr = addr; e.data = data;
    cache_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] msg, input logic [11:0] addr, input logic [31:0] data);
    @(negedge clock);
    c_msg  = msg;
    c_addr = addr;
    c_data = data;
  endtask

  // Waits (bounded) for the line response, checks it is held while the cache
  // still requests, then drops the request and checks the return to idle.
  task automatic finish(input string name);
    int n = 0;
    while (i2c_msg != MEM_RESP && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no MEM_RESP expected MEM_RESP within 200 cycles", name);
    end
    @(negedge clock);
    check({name, "_resp_hold"}, {28'd0, i2c_msg}, {28'd0, MEM_RESP});
    check({name, "_mem_idle"}, {28'd0, i2m_msg}, {28'd0, NO_REQ});
    c_msg = NO_REQ;
    @(negedge clock);
    check({name, "_resp_drop"}, {28'd0, i2c_msg}, {28'd0, NO_REQ});
  endtask

  task automatic check_zero(input string name);
    check({name, "_c_msg"},  {28'd0, i2c_msg},  32'd0);
    check({name, "_c_addr"}, {20'd0, i2c_addr}, 32'd0);
    check({name, "_c_data"}, i2c_data,          32'd0);
    check({name, "_m_msg"},  {28'd0, i2m_msg},  32'd0);
    check({name, "_m_addr"}, {20'd0, i2m_addr}, 32'd0);
    check({name, "_m_data"}, {24'd0, i2m_data}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    reset = 1'b1;
    c_msg = NO_REQ; c_addr = '0; c_data = '0;
    man_msg = NO_REQ; man_addr = '0; man_data = '0;
    model_en = 1'b1;
    delay_tbl = '{0, 0, 0, 0};
    for (int i = 0; i < 4096; i++) mem_arr[i] = 8'h00;
    mem_arr[12'h104] = 8'h11; mem_arr[12'h105] = 8'h22;
    mem_arr[12'h106] = 8'h33; mem_arr[12'h107] = 8'h44;

    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    // Line read with 0/1-cycle memory delays
    delay_tbl = '{0, 1, 0, 1};
    exp_mem(R_REQ, 12'h104, 8'h00, 1'b0); exp_mem(R_REQ, 12'h105, 8'h00, 1'b0);
    exp_mem(R_REQ, 12'h106, 8'h00, 1'b0); exp_mem(R_REQ, 12'h107, 8'h00, 1'b0);
    exp_cache(12'h104, 32'h44332211);
    issue(R_REQ, 12'h104, 32'h0);
    finish("read");

    // Write-back
    delay_tbl = '{1, 0, 0, 0};
    exp_mem(WB_REQ, 12'h200, 8'h66, 1'b1); exp_mem(WB_REQ, 12'h201, 8'h77, 1'b1);
    exp_mem(WB_REQ, 12'h202, 8'h88, 1'b1); exp_mem(WB_REQ, 12'h203, 8'h99, 1'b1);
    exp_cache(12'h200, 32'h99887766);
    issue(WB_REQ, 12'h200, 32'h99887766);
    finish("wb");

    // Flush goes to memory as WB_REQ
    delay_tbl = '{0, 0, 1, 1};
    exp_mem(WB_REQ, 12'h324, 8'h78, 1'b1); exp_mem(WB_REQ, 12'h325, 8'h56, 1'b1);
    exp_mem(WB_REQ, 12'h326, 8'h34, 1'b1); exp_mem(WB_REQ, 12'h327, 8'h12, 1'b1);
    exp_cache(12'h324, 32'h12345678);
    issue(FLUSH, 12'h324, 32'h12345678);
    finish("flush");

    // Memory stall: request must stay asserted; cache message change ignored
    delay_tbl = '{3, 0, 2, 0};
    exp_mem(R_REQ, 12'h104, 8'h00, 1'b0); exp_mem(R_REQ, 12'h105, 8'h00, 1'b0);
    exp_mem(R_REQ, 12'h106, 8'h00, 1'b0); exp_mem(R_REQ, 12'h107, 8'h00, 1'b0);
    exp_cache(12'h104, 32'h44332211);
    issue(R_REQ, 12'h104, 32'h0);
    @(negedge clock); @(negedge clock);
    check("stall_msg",  {28'd0, i2m_msg},  {28'd0, R_REQ});
    check("stall_addr", {20'd0, i2m_addr}, 32'h104);
    c_msg = FLUSH;
    finish("stall");

`ifdef MAIN_MEM_IF_ADDR_CHECK_EN
    // Stale acknowledge for 0x104 held while 0x105 is requested
    model_en = 1'b0;
    exp_cache(12'h104, 32'hA4A3A2A1);
    issue(R_REQ, 12'h104, 32'h0);
    @(negedge clock);
    check("stale_first_addr", {20'd0, i2m_addr}, 32'h104);
    man_msg = MEM_RESP; man_addr = 12'h104; man_data = 8'hA1;
    @(negedge clock);
    check("stale_adv_addr", {20'd0, i2m_addr}, 32'h105);
    man_data = 8'hEE;
    @(negedge clock);
    check("stale_hold_addr", {20'd0, i2m_addr}, 32'h105);
    check("stale_hold_msg",  {28'd0, i2m_msg},  {28'd0, R_REQ});
    man_addr = 12'h105; man_data = 8'hA2;
    @(negedge clock);
    man_addr = 12'h106; man_data = 8'hA3;
    @(negedge clock);
    man_addr = 12'h107; man_data = 8'hA4;
    @(negedge clock);
    man_msg = NO_REQ;
    model_en = 1'b1;
    finish("stale");
`endif

    // Reset after the second word of a read aborts with no response
    delay_tbl = '{0, 0, 0, 0};
    exp_mem(R_REQ, 12'h104, 8'h00, 1'b0); exp_mem(R_REQ, 12'h105, 8'h00, 1'b0);
    start = resp_cnt;
    issue(R_REQ, 12'h104, 32'h0);
    n = 0;
    while (resp_cnt < start + 2 && n < 100) begin
      @(posedge clock);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL abort_wait: got %0d acks expected 2", resp_cnt - start);
    end
    #1;
    reset = 1'b1;
    c_msg = NO_REQ;
    #1;
    check_zero("abort");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_no_resp", {28'd0, i2c_msg}, {28'd0, NO_REQ});

    exp_mem(R_REQ, 12'h104, 8'h00, 1'b0); exp_mem(R_REQ, 12'h105, 8'h00, 1'b0);
    exp_mem(R_REQ, 12'h106, 8'h00, 1'b0); exp_mem(R_REQ, 12'h107, 8'h00, 1'b0);
    exp_cache(12'h104, 32'h44332211);
    issue(R_REQ, 12'h104, 32'h0);
    finish("post_reset");

    // Unaligned request: memory walks the whole line, response echoes 0x106
    delay_tbl = '{1, 1, 0, 0};
    exp_mem(R_REQ, 12'h104, 8'h00, 1'b0); exp_mem(R_REQ, 12'h105, 8'h00, 1'b0);
    exp_mem(R_REQ, 12'h106, 8'h00, 1'b0); exp_mem(R_REQ, 12'h107, 8'h00, 1'b0);
    exp_cache(12'h106, 32'h44332211);
    issue(R_REQ, 12'h106, 32'h0);
    finish("unaligned");

    repeat (3) @(negedge clock);
    check("mem_q_drained",   mem_q.size(),   32'd0);
    check("cache_q_drained", cache_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
